// File: rtl/flash_bus_pkg.sv
// Shared types and constants for the flash bus front end.
package flash_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        ACK    = 2'd2,
        ERR    = 2'd3
    } state_t;

    localparam logic [1:0]  LONG_SIZE      = 2'b00;
    localparam logic [31:0] BLANK_DATA_DEF = 32'hFFFF_FFFF;
    localparam logic [1:0]  DSACK_32       = 2'b00;
    localparam logic [1:0]  DSACK_NONE     = 2'b11;

endpackage

// File: rtl/flash_bus_sync.sv
// Two-flop synchroniser for asynchronous active-low CPU strobes; resets to 1 (negated).
module flash_bus_sync #(
    parameter int W = 1
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/flash_bus_ctrl.sv
// 68030 bus front end for the flash register block: decode, strobe, wait for Term, acknowledge.
// Optional macro FLASH_TIMEOUT_EN adds a STROBE timeout that ends the cycle with a bus error.
module flash_bus_ctrl
    import flash_bus_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR  = 8'h00,
    parameter int          TIMEOUT    = 64,
    parameter logic [31:0] BLANK_DATA = BLANK_DATA_DEF
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        n_AS,
    input  logic        n_DS,
    input  logic        R_W,
    input  logic [1:0]  SIZ,
    input  logic [31:0] ADDR,
    input  logic [31:0] CPU_DATA_IN,
    output logic [31:0] CPU_DATA_OUT,
    output logic        DATA_OE,
    output logic [1:0]  nDSACK,
    output logic        nBERR,
    output logic [23:0] FLASH_ADDR,
    output logic [31:0] FLASH_DATA_IN,
    output logic        FLASH_DATA_RD_,
    output logic        FLASH_DATA_WR,
    input  logic [31:0] FLASH_DATA_OUT,
    input  logic        Term
);

    state_t state, state_nxt;
    logic   s_as, s_ds;
    logic   rw_q;
    logic   qualified, aligned, to_hit;

    flash_bus_sync #(.W(2)) u_sync (
        .CLK  (CLK),
        .nRST (nRST),
        .d    ({n_AS, n_DS}),
        .q    ({s_as, s_ds})
    );

    assign qualified = !s_as && !s_ds && (ADDR[31:24] == BASE_ADDR);
    assign aligned   = (SIZ == LONG_SIZE) && (ADDR[1:0] == 2'b00);

`ifdef FLASH_TIMEOUT_EN
    localparam int             CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] to_cnt;

    // Held at zero outside STROBE, so every STROBE entry starts from a clean count
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            to_cnt <= '0;
        else if (state != STROBE)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + CW'(1);
    end

    assign to_hit = (state == STROBE) && (to_cnt == TO_LAST);
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // CPU withdrawing AS beats a same-cycle Term: nobody is left to acknowledge
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (qualified) state_nxt = aligned ? STROBE : ACK;
            STROBE: begin
                if (s_as)        state_nxt = IDLE;
                else if (Term)   state_nxt = ACK;
                else if (to_hit) state_nxt = ERR;
            end
            ACK:    if (s_as) state_nxt = IDLE;
`ifdef FLASH_TIMEOUT_EN
            ERR:    if (s_as) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        FLASH_DATA_RD_ = !((state == STROBE) && rw_q);
        FLASH_DATA_WR  = (state == STROBE) && !rw_q;
        nDSACK         = (state == ACK) ? DSACK_32 : DSACK_NONE;
        DATA_OE        = (state == ACK) && rw_q;
`ifdef FLASH_TIMEOUT_EN
        nBERR          = (state != ERR);
`else
        nBERR          = 1'b1;
`endif
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rw_q          <= 1'b1;
            FLASH_ADDR    <= '0;
            FLASH_DATA_IN <= '0;
            CPU_DATA_OUT  <= '0;
        end else if (state == IDLE && qualified) begin
            rw_q       <= R_W;
            FLASH_ADDR <= ADDR[23:0];
            if (!R_W)
                FLASH_DATA_IN <= CPU_DATA_IN;
            if (R_W && !aligned)
                CPU_DATA_OUT <= BLANK_DATA;
        end else if (state == STROBE && !s_as && Term && rw_q) begin
            CPU_DATA_OUT <= FLASH_DATA_OUT;
        end
    end

endmodule
